line_follow_ctrl: RTL and testbench
===================================

# line_follow_ctrl

Sequencing controller for the rover's two drive motors. It debounces the 3-bit inductive line sensor and the proximity sensor and runs a follow/turn/lost/obstacle state machine. Per-wheel direction (leftOut, rightOut) and PWM-gated enables (leftEn, rightEn) are generated from that state. It replaces direct combinational sensor-to-motor mapping and drives the H-bridge pins at the top level.

## Interface
- PWM_BITS, 8, width of the free-running PWM counter
- DUTY_FWD, 192, compare value for straight driving
- DUTY_TURN, 128, compare value for both wheels while pivoting
- DEB_CYCLES, 4, consecutive identical induct samples required to accept a new pattern (≥1)
- LOST_TIMEOUT, 1000, cycles in LOST before HALT
- PROX_HOLD, 200, consecutive cycles proxim must read low before leaving OBST
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- run  in  1  level enable; low forces IDLE
- induct  in  3  line sensors; [2]=left, [1]=centre, [0]=right, 1 = line detected
- proxim  in  1  obstacle detected, asynchronous to clk
- leftOut  out  1  left wheel direction, 1 = forward
- rightOut  out  1  right wheel direction, 1 = forward
- leftEn  out  1  left wheel enable (PWM)
- rightEn  out  1  right wheel enable (PWM)
- state  out  3  current state encoding, for debug LEDs

## Operation
- States: IDLE=0, FWD=1, LEFT=2, RIGHT=3, LOST=4, OBST=5, HALT=6.
- Stable pattern S is the debounced induct value. It is reset to 000.
  - 010 and 111 mean FWD.
  - 100 and 110 mean LEFT.
  - 001 and 011 mean RIGHT.
  - 000 means LOST.
  - 101 (fork) means stay in the current state; from LOST, 101 means FWD.
- Transitions, highest priority first:
  1. run=0 goes to IDLE from any state.
  2. Synchronised proxim=1 goes to OBST from any state except IDLE and HALT.
  3. From IDLE, run=1 goes to FWD.
  4. From OBST, hold_cnt reaching PROX_HOLD goes to the state decoded from S.
  5. From LOST, lost_cnt reaching LOST_TIMEOUT goes to HALT. HALT is sticky until run=0.
  6. From FWD, LEFT, RIGHT or LOST, the state decoded from S.
- last_side register:
  - Set to LEFT on entering LEFT and to RIGHT on entering RIGHT.
  - Reset value is LEFT.
  - LOST pivots toward last_side.
- Outputs by state:
  - FWD: leftOut=1, rightOut=1, both enables use DUTY_FWD.
  - LEFT pivot: leftOut=0, rightOut=1, both enables use DUTY_TURN.
  - RIGHT pivot: leftOut=1, rightOut=0, both enables use DUTY_TURN.
  - LOST: same outputs as LEFT or RIGHT, chosen by last_side.
  - IDLE, OBST, HALT: all four outputs 0.
- PWM:
  - pwm_cnt is free-running modulo 2^PWM_BITS and reset to 0.
  - When enabled, En = (pwm_cnt < duty), an unsigned PWM_BITS-wide compare.
  - duty=0 gives constant 0; duty=2^PWM_BITS-1 gives high 255 of every 256 cycles.

## Timing
- Reset values: all outputs 0, state=IDLE, S=000, all counters 0, last_side=LEFT.
- proxim passes through a 2-flop synchroniser and is not debounced.
  - State reads OBST 3 clk edges after proxim rises.
  - Enables drop on that same edge, because outputs are registered from the next state.
- Debounce:
  - deb_cnt counts samples equal to the previous sample and resets on any change.
  - S updates on the cycle the DEB_CYCLES-th identical sample is registered.
  - State follows 1 cycle later and outputs on the same edge as state.
  - Total latency from a stable induct change to a motor output change is DEB_CYCLES+1 cycles.
- hold_cnt and lost_cnt:
  - hold_cnt clears on entry to OBST and whenever synchronised proxim=1. It saturates at PROX_HOLD.
  - lost_cnt clears on any exit from or re-entry to LOST. It saturates at LOST_TIMEOUT.
- Simultaneous events:
  - proxim during a LOST timeout goes to OBST, and lost_cnt clears.
  - run falling while in OBST goes to IDLE.
- Asserting rst mid-operation forces all outputs to 0 immediately, without waiting for clk.

## Structure
- rover_pkg holds:
  - the state encoding constants;
  - the sensor pattern constants (PAT_FWD=010, PAT_ALL=111, PAT_FORK=101, PAT_NONE=000);
  - the LEFT/RIGHT encoding for last_side.
- One sub-module, sensor_debounce, parameterised on WIDTH and DEB_CYCLES. It is instantiated once for induct.
- The proxim synchroniser, FSM, counters and PWM stay in line_follow_ctrl.

## Test plan
- Bench parameters: DEB_CYCLES=4, PROX_HOLD=20, LOST_TIMEOUT=50, PWM_BITS=4, DUTY_FWD=12, DUTY_TURN=8.
- Reset then run=1 with induct=010: state=FWD (1), both directions 1, both En high 12 of every 16 cycles.
- induct 010→110 held: state=LEFT exactly 5 cycles after the change, leftOut=0, rightOut=1, En high 8 of every 16 cycles. A 2-cycle glitch to 001 must produce no state change.
- From RIGHT, induct=000: LOST pivots right. After 50 cycles the state is HALT with all outputs 0. Driving induct=010 keeps HALT until run toggles 0→1.
- In FWD, pulse proxim high for 10 cycles: OBST 3 edges after the rise with enables 0. The state returns to FWD exactly 20 cycles after synchronised proxim falls. A re-pulse at cycle 15 restarts the hold count.
- In LEFT, induct=101: the state stays LEFT. Asserting rst asynchronously mid-cycle forces all outputs to 0 and state=0 before the next clk edge.

Source files
------------

// File: rtl/rover_pkg.sv
// Shared encodings for the rover drive controller: FSM states, line-sensor
// patterns, pivot side, and the pattern-to-state decode.
package rover_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FWD   = 3'd1,
    ST_LEFT  = 3'd2,
    ST_RIGHT = 3'd3,
    ST_LOST  = 3'd4,
    ST_OBST  = 3'd5,
    ST_HALT  = 3'd6
  } state_e;

  typedef enum logic {
    SIDE_LEFT  = 1'b0,
    SIDE_RIGHT = 1'b1
  } side_e;

  // Sensor bit order is {left, centre, right}.
  localparam logic [2:0] PAT_FWD        = 3'b010;
  localparam logic [2:0] PAT_ALL        = 3'b111;
  localparam logic [2:0] PAT_FORK       = 3'b101;
  localparam logic [2:0] PAT_NONE       = 3'b000;
  localparam logic [2:0] PAT_LEFT       = 3'b100;
  localparam logic [2:0] PAT_LEFT_WIDE  = 3'b110;
  localparam logic [2:0] PAT_RIGHT      = 3'b001;
  localparam logic [2:0] PAT_RIGHT_WIDE = 3'b011;

  // A fork keeps the current heading, except that it recovers a lost rover.
  function automatic state_e decode_pattern(input logic [2:0] pat, input state_e cur);
    state_e res;
    case (pat)
      PAT_FWD, PAT_ALL:             res = ST_FWD;
      PAT_LEFT, PAT_LEFT_WIDE:      res = ST_LEFT;
      PAT_RIGHT, PAT_RIGHT_WIDE:    res = ST_RIGHT;
      PAT_FORK:                     res = (cur == ST_LOST) ? ST_FWD : cur;
      default:                      res = ST_LOST;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Accepts a new input pattern only after DEB_CYCLES consecutive identical
// samples; the output updates on the edge that registers the last of them.
module sensor_debounce #(
  parameter int WIDTH      = 3,
  parameter int DEB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] stable_o
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic [WIDTH-1:0] sample_q;
  logic [WIDTH-1:0] stable_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    if (raw_i != sample_q)                   cnt_d = CNT_W'(1);
    else if (cnt_q == CNT_W'(DEB_CYCLES))    cnt_d = cnt_q;
    else                                     cnt_d = cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      sample_q <= raw_i;
      cnt_q    <= cnt_d;
      if (cnt_d == CNT_W'(DEB_CYCLES)) stable_q <= raw_i;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/line_follow_ctrl.sv
// Line-following drive sequencer: debounced line pattern and synchronised
// proximity drive a follow/turn/lost/obstacle FSM with registered PWM outputs.
module line_follow_ctrl
  import rover_pkg::*;
#(
  parameter int PWM_BITS     = 8,
  parameter int DUTY_FWD     = 192,
  parameter int DUTY_TURN    = 128,
  parameter int DEB_CYCLES   = 4,
  parameter int LOST_TIMEOUT = 1000,
  parameter int PROX_HOLD    = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [2:0] induct,
  input  logic       proxim,
  output logic       leftOut,
  output logic       rightOut,
  output logic       leftEn,
  output logic       rightEn,
  output logic [2:0] state
);

  localparam int LOST_W = $clog2(LOST_TIMEOUT + 1);
  localparam int HOLD_W = $clog2(PROX_HOLD + 1);
  localparam logic [PWM_BITS-1:0] DUTY_FWD_C  = PWM_BITS'(DUTY_FWD);
  localparam logic [PWM_BITS-1:0] DUTY_TURN_C = PWM_BITS'(DUTY_TURN);

  logic [2:0]          pat_s;
  logic                prox_meta_q, prox_sync_q;
  state_e              state_q, state_d;
  side_e               side_q, side_d;
  logic [LOST_W-1:0]   lost_cnt_q, lost_cnt_d, lost_inc;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d, hold_inc;
  logic [PWM_BITS-1:0] pwm_cnt_q, duty_d;
  logic                left_dir_d, right_dir_d;
  logic                left_out_q, right_out_q, en_q;

  sensor_debounce #(
    .WIDTH      (3),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_induct_deb (
    .clk      (clk),
    .rst      (rst),
    .raw_i    (induct),
    .stable_o (pat_s)
  );

  always_comb begin
    lost_inc = (lost_cnt_q == LOST_W'(LOST_TIMEOUT)) ? lost_cnt_q : lost_cnt_q + LOST_W'(1);
    hold_inc = (hold_cnt_q == HOLD_W'(PROX_HOLD))    ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);

    state_d = state_q;
    if (!run) begin
      state_d = ST_IDLE;
    end else if (prox_sync_q && state_q != ST_IDLE && state_q != ST_HALT) begin
      state_d = ST_OBST;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_FWD;
        ST_OBST: if (hold_inc == HOLD_W'(PROX_HOLD)) state_d = decode_pattern(pat_s, state_q);
        ST_LOST: state_d = (lost_inc == LOST_W'(LOST_TIMEOUT)) ? ST_HALT
                                                               : decode_pattern(pat_s, state_q);
        ST_FWD, ST_LEFT, ST_RIGHT: state_d = decode_pattern(pat_s, state_q);
        default: state_d = state_q;
      endcase
    end

    // Counters run only while staying in their state, so any exit or entry clears them.
    hold_cnt_d = (state_q == ST_OBST && state_d == ST_OBST && !prox_sync_q) ? hold_inc : '0;
    lost_cnt_d = (state_q == ST_LOST && state_d == ST_LOST) ? lost_inc : '0;

    side_d = side_q;
    if (state_d == ST_LEFT)  side_d = SIDE_LEFT;
    if (state_d == ST_RIGHT) side_d = SIDE_RIGHT;

    left_dir_d  = 1'b0;
    right_dir_d = 1'b0;
    duty_d      = '0;
    case (state_d)
      ST_FWD:   begin left_dir_d = 1'b1; right_dir_d = 1'b1; duty_d = DUTY_FWD_C;  end
      ST_LEFT:  begin right_dir_d = 1'b1;                    duty_d = DUTY_TURN_C; end
      ST_RIGHT: begin left_dir_d = 1'b1;                     duty_d = DUTY_TURN_C; end
      ST_LOST:  begin
        left_dir_d  = (side_d == SIDE_RIGHT);
        right_dir_d = (side_d == SIDE_LEFT);
        duty_d      = DUTY_TURN_C;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prox_meta_q <= 1'b0;
      prox_sync_q <= 1'b0;
      state_q     <= ST_IDLE;
      side_q      <= SIDE_LEFT;
      lost_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      pwm_cnt_q   <= '0;
      left_out_q  <= 1'b0;
      right_out_q <= 1'b0;
      en_q        <= 1'b0;
    end else begin
      prox_meta_q <= proxim;
      prox_sync_q <= prox_meta_q;
      state_q     <= state_d;
      side_q      <= side_d;
      lost_cnt_q  <= lost_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      pwm_cnt_q   <= pwm_cnt_q + PWM_BITS'(1);
      left_out_q  <= left_dir_d;
      right_out_q <= right_dir_d;
      en_q        <= (pwm_cnt_q < duty_d);
    end
  end

  assign leftOut  = left_out_q;
  assign rightOut = right_out_q;
  assign leftEn   = en_q;
  assign rightEn  = en_q;
  assign state    = state_q;

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Directed bench for line_follow_ctrl with short debounce, hold and timeout
// parameters; expected values are hand-derived cycle counts.
module tb_line_follow_ctrl;

  logic       clk = 1'b0;
  logic       rst, run, proxim;
  logic [2:0] induct;
  logic       leftOut, rightOut, leftEn, rightEn;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  line_follow_ctrl #(
    .PWM_BITS     (4),
    .DUTY_FWD     (12),
    .DUTY_TURN    (8),
    .DEB_CYCLES   (4),
    .LOST_TIMEOUT (50),
    .PROX_HOLD    (20)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .induct   (induct),
    .proxim   (proxim),
    .leftOut  (leftOut),
    .rightOut (rightOut),
    .leftEn   (leftEn),
    .rightEn  (rightEn),
    .state    (state)
  );

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_drive(input string tag, input int st, input int lo, input int ro);
    check({tag, "_state"}, 32'(state), st);
    check({tag, "_leftOut"}, 32'(leftOut), lo);
    check({tag, "_rightOut"}, 32'(rightOut), ro);
  endtask

  task automatic count_en(input int n, output int l_cnt, output int r_cnt);
    l_cnt = 0;
    r_cnt = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (leftEn === 1'b1)  l_cnt++;
      if (rightEn === 1'b1) r_cnt++;
    end
  endtask

  int l_hi, r_hi, bad;

  initial begin
    rst = 1'b1; run = 1'b0; induct = 3'b010; proxim = 1'b0;
    step(2);
    check_drive("reset", 0, 0, 0);
    check("reset_leftEn", 32'(leftEn), 0);
    check("reset_rightEn", 32'(rightEn), 0);
    rst = 1'b0;

    // Let the 010 pattern settle while idle, then enable.
    step(8);
    check("idle_run0", 32'(state), 0);
    run = 1'b1;
    step(1);
    check_drive("fwd", 1, 1, 1);
    count_en(16, l_hi, r_hi);
    check("fwd_left_duty", 32'(l_hi), 12);
    check("fwd_right_duty", 32'(r_hi), 12);

    induct = 3'b110;
    step(4);
    check("left_lat4", 32'(state), 1);
    step(1);
    check_drive("left_lat5", 2, 0, 1);
    count_en(16, l_hi, r_hi);
    check("left_left_duty", 32'(l_hi), 8);
    check("left_right_duty", 32'(r_hi), 8);

    bad = 0;
    induct = 3'b001;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) induct = 3'b110;
      step(1);
      if (state !== 3'd2) bad++;
    end
    check("glitch_no_change", 32'(bad), 0);

    induct = 3'b101;
    step(8);
    check("fork_stays_left", 32'(state), 2);

    induct = 3'b011;
    step(4);
    check("right_lat4", 32'(state), 2);
    step(1);
    check_drive("right_lat5", 3, 1, 0);

    induct = 3'b000;
    step(5);
    check_drive("lost_pivot_right", 4, 1, 0);
    count_en(16, l_hi, r_hi);
    check("lost_left_duty", 32'(l_hi), 8);
    check("lost_right_duty", 32'(r_hi), 8);
    step(33);
    check("lost_49", 32'(state), 4);
    step(1);
    check_drive("halt_50", 6, 0, 0);
    check("halt_leftEn", 32'(leftEn), 0);
    check("halt_rightEn", 32'(rightEn), 0);

    induct = 3'b010;
    step(10);
    check("halt_sticky", 32'(state), 6);
    run = 1'b0;
    step(1);
    check("halt_run0_idle", 32'(state), 0);
    run = 1'b1;
    step(1);
    check("rerun_fwd", 32'(state), 1);

    // Single 10-cycle proximity pulse; synchronised proxim falls 12 edges after the rise.
    step(3);
    proxim = 1'b1;
    step(2);
    check("obst_edge2", 32'(state), 1);
    step(1);
    check_drive("obst_edge3", 5, 0, 0);
    check("obst_leftEn", 32'(leftEn), 0);
    check("obst_rightEn", 32'(rightEn), 0);
    step(7);
    proxim = 1'b0;
    step(21);
    check("obst_hold_19", 32'(state), 5);
    step(1);
    check("obst_return_20", 32'(state), 1);

    // Re-pulse 15 cycles into the hold: return moves to 20 cycles after the second fall.
    step(3);
    proxim = 1'b1;
    step(10);
    check("repulse_obst", 32'(state), 5);
    proxim = 1'b0;
    step(17);
    proxim = 1'b1;
    step(3);
    proxim = 1'b0;
    step(2);
    check("repulse_no_early_return", 32'(state), 5);
    step(19);
    check("repulse_hold_19", 32'(state), 5);
    step(1);
    check("repulse_return_20", 32'(state), 1);

    proxim = 1'b1;
    step(3);
    check("obst_before_run0", 32'(state), 5);
    run = 1'b0;
    step(1);
    check("obst_run0_idle", 32'(state), 0);
    proxim = 1'b0;
    step(4);
    run = 1'b1;
    step(1);
    check("idle_to_fwd", 32'(state), 1);

    induct = 3'b110;
    step(6);
    check("pre_rst_left", 32'(state), 2);
    #3 rst = 1'b1;
    #1;
    check_drive("async_rst", 0, 0, 0);
    check("async_rst_leftEn", 32'(leftEn), 0);
    check("async_rst_rightEn", 32'(rightEn), 0);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
